// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit between execute stage and a word-wide data memory
// Sub-word stores are done as read-modify-write; one request in flight at a time.
module mem_access_unit #(
   parameter int AWIDTH  = 32,
   parameter int ALENGTH = 128
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ReqValid,
   output logic              ReqReady,
   input  logic              ReqWrite,
   input  logic [1:0]        ReqSize,
   input  logic              ReqSigned,
   input  logic [AWIDTH-1:0] ReqAddr,
   input  logic [AWIDTH-1:0] ReqWData,
   output logic              RespValid,
   output logic [AWIDTH-1:0] RespData,
   output logic              RespErr,
   output logic              MemWE,
   output logic [AWIDTH-1:0] MemAddr,
   output logic [AWIDTH-1:0] MemWData,
   input  logic [AWIDTH-1:0] MemRData
);

   typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_RESP} state_e;

   state_e            state_q;
   logic              write_q;
   logic              signed_q;
   logic              err_q;
   logic [1:0]        size_q;
   logic [1:0]        off_q;
   logic [AWIDTH-1:0] idx_q;
   logic [AWIDTH-1:0] wdata_q;
   logic [AWIDTH-1:0] word_q;
   logic [AWIDTH-1:0] resp_q;

   logic              req_err_d;
   logic [4:0]        lane_shift_d;
   logic [7:0]        byte_d;
   logic [15:0]       half_d;
   logic [AWIDTH-1:0] load_d;
   logic [AWIDTH-1:0] mask_d;
   logic [AWIDTH-1:0] merge_d;

   always_comb begin
      req_err_d = 1'b0;
      case (ReqSize)
         2'b01:   req_err_d = ReqAddr[0];
         2'b10:   req_err_d = |ReqAddr[1:0];
         2'b11:   req_err_d = 1'b1;
         default: req_err_d = 1'b0;
      endcase
      if ((ReqAddr >> 2) >= AWIDTH'(ALENGTH)) req_err_d = 1'b1;
   end

   // Halfwords are always aligned here, so one lane shift serves both sizes.
   assign lane_shift_d = {off_q, 3'b000};
   assign byte_d       = 8'(MemRData >> lane_shift_d);
   assign half_d       = 16'(MemRData >> lane_shift_d);

   always_comb begin
      load_d = MemRData;
      mask_d = AWIDTH'(16'hFFFF) << lane_shift_d;
      case (size_q)
         2'b00: begin
            load_d = {{(AWIDTH-8){byte_d[7] & signed_q}}, byte_d};
            mask_d = AWIDTH'(8'hFF) << lane_shift_d;
         end
         2'b01:   load_d = {{(AWIDTH-16){half_d[15] & signed_q}}, half_d};
         default: load_d = MemRData;
      endcase
      merge_d = (MemRData & ~mask_d) | ((wdata_q << lane_shift_d) & mask_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         err_q    <= 1'b0;
         size_q   <= 2'b00;
         off_q    <= 2'b00;
         idx_q    <= '0;
         wdata_q  <= '0;
         word_q   <= '0;
         resp_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (ReqValid) begin
                  write_q  <= ReqWrite;
                  signed_q <= ReqSigned;
                  size_q   <= ReqSize;
                  off_q    <= ReqAddr[1:0];
                  idx_q    <= ReqAddr >> 2;
                  wdata_q  <= ReqWData;
                  word_q   <= ReqWData;
                  resp_q   <= '0;
                  err_q    <= req_err_d;
                  if (req_err_d)                         state_q <= S_RESP;
                  else if (ReqWrite && ReqSize == 2'b10) state_q <= S_WR;
                  else                                   state_q <= S_RD;
               end
            end
            S_RD:  state_q <= S_CAP;
            S_CAP: begin
               if (write_q) begin
                  word_q  <= merge_d;
                  state_q <= S_WR;
               end else begin
                  resp_q  <= load_d;
                  state_q <= S_RESP;
               end
            end
            S_WR:    state_q <= S_RESP;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Outputs are decodes of registered state, forced quiet while reset is held.
   assign ReqReady  = !rst && state_q == S_IDLE;
   assign MemWE     = !rst && state_q == S_WR;
   assign MemAddr   = (!rst && (state_q == S_RD || state_q == S_CAP || state_q == S_WR)) ? idx_q : '0;
   assign MemWData  = MemWE ? word_q : '0;
   assign RespValid = !rst && state_q == S_RESP;
   assign RespErr   = RespValid && err_q;
   assign RespData  = (RespValid && !err_q) ? resp_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Stimulus pushes expected responses and writes; a negedge monitor pops and compares.
module tb_mem_access_unit;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          cyc;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ReqValid = 1'b0;
   logic        ReqReady;
   logic        ReqWrite = 1'b0;
   logic [1:0]  ReqSize = 2'b00;
   logic        ReqSigned = 1'b0;
   logic [31:0] ReqAddr = '0;
   logic [31:0] ReqWData = '0;
   logic        RespValid;
   logic [31:0] RespData;
   logic        RespErr;
   logic        MemWE;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic [31:0] MemRData = '0;

   logic [31:0] mem [0:127];
   resp_t       rq[$];
   wr_t         wq[$];
   resp_t       re;
   wr_t         we;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   mem_access_unit #(.AWIDTH(32), .ALENGTH(128)) dut (
      .clk(clk), .rst(rst),
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
      .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
      .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr),
      .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData), .MemRData(MemRData)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (MemWE) mem[MemAddr[6:0]] <= MemWData;
      MemRData <= mem[MemAddr[6:0]];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         chk("reset_outputs", {28'd0, ReqReady, RespValid, RespErr, MemWE} | RespData | MemAddr | MemWData, 32'd0);
      end else begin
         if (RespValid) begin
            if (rq.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
            else begin
               re = rq.pop_front();
               chk("resp_err", {31'd0, RespErr}, {31'd0, re.err});
               chk("resp_data", RespData, re.data);
               chk("resp_cycle", 32'(cyc), 32'(re.cyc));
            end
         end else begin
            chk("quiet_resp", RespData | {31'd0, RespErr}, 32'd0);
         end
         if (MemWE) begin
            if (wq.size() == 0) chk("unexpected_memwe", 32'd1, 32'd0);
            else begin
               we = wq.pop_front();
               chk("wr_addr", MemAddr, we.addr);
               chk("wr_data", MemWData, we.data);
               chk("wr_cycle", 32'(cyc), 32'(we.cyc));
            end
         end
      end
   end

   // wlat = 0 means no memory write expected; exp_wait < 0 skips the ready-wait check.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic e_err, input logic [31:0] e_data, input int rlat,
                        input int wlat, input logic [31:0] e_wdata,
                        input logic hold, input int exp_wait);
      int waited = 0;
      @(negedge clk);
      ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
      ReqValid = 1'b1;
      while (!ReqReady && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ReqReady) begin
         chk("accept_timeout", 32'd1, 32'd0);
         ReqValid = 1'b0;
         return;
      end
      if (exp_wait >= 0) chk("ready_wait", 32'(waited), 32'(exp_wait));
      rq.push_back('{err: e_err, data: e_data, cyc: cyc + rlat});
      if (wlat > 0) wq.push_back('{addr: a >> 2, data: e_wdata, cyc: cyc + wlat});
      @(posedge clk);
      #1;
      if (!hold) ReqValid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || wq.size() != 0) && n < 30) begin
         @(negedge clk);
         n++;
      end
      if (rq.size() != 0 || wq.size() != 0) begin
         chk("drain_timeout", 32'(rq.size() + wq.size()), 32'd0);
         rq.delete();
         wq.delete();
      end
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] e_word);
      if (sz == 2'b10) issue(1'b1, sz, 1'b0, a, wd, 1'b0, 32'd0, 2, 1, e_word, 1'b0, 0);
      else             issue(1'b1, sz, 1'b0, a, wd, 1'b0, 32'd0, 4, 3, e_word, 1'b0, 0);
      drain();
   endtask

   task automatic ld(input logic [1:0] sz, input logic sg, input logic [31:0] a,
                     input logic [31:0] e_data);
      issue(1'b0, sz, sg, a, 32'd0, 1'b0, e_data, 3, 0, 32'd0, 1'b0, 0);
      drain();
   endtask

   task automatic bad(input logic w, input logic [1:0] sz, input logic [31:0] a);
      issue(w, sz, 1'b1, a, 32'hFFFF_FFFF, 1'b1, 32'd0, 1, 0, 32'd0, 1'b0, 0);
      drain();
   endtask

   initial begin
      for (int i = 0; i < 128; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, ReqReady}, 32'd1);

      st(2'b10, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      st(2'b10, 32'h10, 32'h1122_3344, 32'h1122_3344);
      st(2'b00, 32'h12, 32'h0000_00AA, 32'h11AA_3344);
      ld(2'b10, 1'b1, 32'h10, 32'h11AA_3344);

      st(2'b10, 32'h10, 32'h8000_F0FF, 32'h8000_F0FF);
      ld(2'b00, 1'b1, 32'h10, 32'hFFFF_FFFF);
      ld(2'b01, 1'b0, 32'h12, 32'h0000_8000);
      ld(2'b01, 1'b1, 32'h12, 32'hFFFF_8000);
      ld(2'b00, 1'b1, 32'h11, 32'hFFFF_FFF0);
      ld(2'b00, 1'b0, 32'h13, 32'h0000_0080);
      ld(2'b01, 1'b1, 32'h10, 32'hFFFF_F0FF);

      st(2'b10, 32'h14, 32'h1234_5678, 32'h1234_5678);
      st(2'b01, 32'h16, 32'h0000_ABCD, 32'hABCD_5678);
      st(2'b00, 32'h17, 32'h0000_01FF, 32'hFFCD_5678);
      ld(2'b01, 1'b1, 32'h14, 32'h0000_5678);
      ld(2'b00, 1'b0, 32'h15, 32'h0000_0056);
      ld(2'b00, 1'b1, 32'h17, 32'hFFFF_FFFF);
      ld(2'b10, 1'b1, 32'h14, 32'hFFCD_5678);

      st(2'b10, 32'h1FC, 32'hC0FF_EE11, 32'hC0FF_EE11);
      ld(2'b00, 1'b1, 32'h1FF, 32'hFFFF_FFC0);
      ld(2'b01, 1'b0, 32'h1FE, 32'h0000_C0FF);

      bad(1'b0, 2'b10, 32'h06);
      bad(1'b0, 2'b01, 32'h03);
      bad(1'b0, 2'b11, 32'h10);
      bad(1'b0, 2'b10, 32'h200);
      bad(1'b1, 2'b00, 32'h200);
      bad(1'b1, 2'b01, 32'h05);
      bad(1'b1, 2'b10, 32'h12);
      chk("err_mem4", mem[4], 32'h8000_F0FF);
      chk("err_mem1", mem[1], 32'd0);
      chk("err_mem5", mem[5], 32'hFFCD_5678);

      issue(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1'b0, 32'h8000_F0FF, 3, 0, 32'd0, 1'b1, 0);
      issue(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 1'b0, 32'hFFCD_5678, 3, 0, 32'd0, 1'b0, 3);
      drain();

      // Byte store aborted by reset while in CAP: no write and no response may follow.
      @(negedge clk);
      ReqWrite = 1'b1; ReqSize = 2'b00; ReqSigned = 1'b0; ReqAddr = 32'h12; ReqWData = 32'h55;
      ReqValid = 1'b1;
      chk("abort_accept_ready", {31'd0, ReqReady}, 32'd1);
      @(posedge clk);
      #1 ReqValid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_abort", {31'd0, ReqReady}, 32'd1);
      repeat (8) @(negedge clk);
      chk("abort_mem4", mem[4], 32'h8000_F0FF);
      ld(2'b10, 1'b0, 32'h10, 32'h8000_F0FF);

      chk("queues_empty", 32'(rq.size() + wq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
